// File: rtl/ex_muldiv.sv
// Iterative RV64M multiply/divide unit for the EX stage (shift-add multiply, restoring divide).
// Define MULDIV_FAST_MUL_EN to replace the iterative multiplier with a single-cycle one.
`ifndef DATA_WIDTH
`define DATA_WIDTH 64
`endif

module ex_muldiv #(
  parameter int DW    = `DATA_WIDTH,
  parameter int CNT_W = 7
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start_i,
  input  logic          hold_n_i,
  input  logic          flush_i,
  input  logic [2:0]    funct3_i,
  input  logic          word_i,
  input  logic [DW-1:0] op_num1_i,
  input  logic [DW-1:0] op_num2_i,
  output logic [DW-1:0] result_o,
  output logic          done_o,
  output logic          busy_o,
  output logic          hold_n_o
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIXUP, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [2*DW-1:0]   acc_q;
  logic [DW-1:0]     opb_q;
  logic [DW-1:0]     result_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [2:0]        funct3_q;
  logic              word_q, sign1_q, sign2_q;

  function automatic logic [DW-1:0] wsext(input logic [DW-1:0] v, input logic w);
    return w ? {{(DW-32){v[31]}}, v[31:0]} : v;
  endfunction

  function automatic logic [DW-1:0] mul_fix(input logic [2*DW-1:0] p, input logic neg,
                                             input logic high, input logic w);
    logic [2*DW-1:0] s;
    s = neg ? -p : p;
    return wsext(high ? s[2*DW-1:DW] : s[DW-1:0], w);
  endfunction

  // Operand preparation from the ID/EX register (cycle 0)
  logic          op1_signed, op2_signed, is_div, accept;
  logic          sign1, sign2, div_zero, div_ovf, special, direct_done;
  logic [DW-1:0] ext1, ext2, mag1, mag2, min_neg, special_res;

  always_comb begin
    op1_signed = 1'b0;
    op2_signed = 1'b0;
    case (funct3_i)
      3'b000, 3'b001, 3'b100, 3'b110: begin
        op1_signed = 1'b1;
        op2_signed = 1'b1;
      end
      3'b010:  op1_signed = 1'b1;
      default: ;
    endcase
    is_div  = funct3_i[2];
    ext1    = word_i ? {{(DW-32){op1_signed & op_num1_i[31]}}, op_num1_i[31:0]} : op_num1_i;
    ext2    = word_i ? {{(DW-32){op2_signed & op_num2_i[31]}}, op_num2_i[31:0]} : op_num2_i;
    sign1   = op1_signed & ext1[DW-1];
    sign2   = op2_signed & ext2[DW-1];
    mag1    = sign1 ? -ext1 : ext1;
    mag2    = sign2 ? -ext2 : ext2;
    min_neg = word_i ? {{(DW-31){1'b1}}, 31'b0} : {1'b1, {(DW-1){1'b0}}};
    div_zero = is_div & (ext2 == '0);
    div_ovf  = is_div & op1_signed & (ext1 == min_neg) & (ext2 == '1);
    special  = div_zero | div_ovf;
    if (div_zero) special_res = funct3_i[1] ? wsext(ext1, word_i) : '1;
    else          special_res = funct3_i[1] ? '0 : ext1;
    accept = start_i & hold_n_i & ~flush_i;
  end

`ifdef MULDIV_FAST_MUL_EN
  logic [2*DW-1:0] fast_prod;
  logic [DW-1:0]   fast_res;
  assign fast_prod   = {{DW{1'b0}}, mag1} * {{DW{1'b0}}, mag2};
  assign fast_res    = mul_fix(fast_prod, sign1 ^ sign2, funct3_i != 3'b000, word_i);
  assign direct_done = special | ~is_div;
`else
  assign direct_done = special;
`endif

  // One iteration step; acc_q holds {partial/remainder, multiplier/quotient}
  logic [DW:0]       mul_sum, div_shift, div_diff;
  logic [2*DW-1:0]   acc_step;
  logic [CNT_W-1:0]  last_cnt;
  logic [DW-1:0]     quo, rem, fix_res;

  always_comb begin
    mul_sum   = {1'b0, acc_q[2*DW-1:DW]} + (acc_q[0] ? {1'b0, opb_q} : '0);
    div_shift = {acc_q[2*DW-1:DW], acc_q[DW-1]};
    div_diff  = div_shift - {1'b0, opb_q};
    if (funct3_q[2])
      acc_step = div_diff[DW] ? {div_shift[DW-1:0], acc_q[DW-2:0], 1'b0}
                              : {div_diff[DW-1:0],  acc_q[DW-2:0], 1'b1};
    else
      acc_step = {mul_sum, acc_q[DW-1:1]};
    last_cnt = word_q ? CNT_W'(31) : CNT_W'(DW-1);
    quo = acc_q[DW-1:0];
    rem = acc_q[2*DW-1:DW];
    // A 32-step multiply leaves the product 32 bits up from where a full run puts it
    if (funct3_q[2])
      fix_res = wsext(funct3_q[1] ? (sign1_q ? -rem : rem)
                                  : ((sign1_q ^ sign2_q) ? -quo : quo), word_q);
    else
      fix_res = mul_fix(word_q ? (acc_q >> 32) : acc_q, sign1_q ^ sign2_q,
                        funct3_q != 3'b000, word_q);
  end

  always_comb begin
    state_d  = state_q;
    hold_n_o = 1'b1;
    case (state_q)
      S_IDLE: if (accept) begin
        hold_n_o = 1'b0;
        state_d  = direct_done ? S_DONE : S_CALC;
      end
      S_CALC: begin
        hold_n_o = 1'b0;
        if (cnt_q == last_cnt) state_d = S_FIXUP;
      end
      S_FIXUP: begin
        hold_n_o = 1'b0;
        state_d  = S_DONE;
      end
      S_DONE:  if (hold_n_i) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (flush_i) begin
      state_d  = S_IDLE;
      hold_n_o = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      acc_q    <= '0;
      opb_q    <= '0;
      result_q <= '0;
      cnt_q    <= '0;
      funct3_q <= '0;
      word_q   <= 1'b0;
      sign1_q  <= 1'b0;
      sign2_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: if (accept) begin
          funct3_q <= funct3_i;
          word_q   <= word_i;
          sign1_q  <= sign1;
          sign2_q  <= sign2;
          cnt_q    <= '0;
          opb_q    <= is_div ? mag2 : mag1;
          // Word dividends are pre-shifted so 32 steps consume all their bits
          acc_q    <= {{DW{1'b0}}, is_div ? (word_i ? mag1 << 32 : mag1) : mag2};
          if (special) result_q <= special_res;
`ifdef MULDIV_FAST_MUL_EN
          else if (!is_div) result_q <= fast_res;
`endif
        end
        S_CALC: begin
          acc_q <= acc_step;
          cnt_q <= cnt_q + 1'b1;
        end
        S_FIXUP: result_q <= fix_res;
        default: ;
      endcase
    end
  end

  assign result_o = result_q;
  assign done_o   = (state_q == S_DONE);
  assign busy_o   = (state_q != S_IDLE);

endmodule

// File: tb/tb_ex_muldiv.sv
// Bench for ex_muldiv: table-driven vectors, random ops against a behavioural model,
// and hand-written flush / hold / reset sequences.
module tb_ex_muldiv;
  localparam int DW = 64;

  logic          clk = 1'b0;
  logic          rst_n, start_i, hold_n_i, flush_i, word_i;
  logic [2:0]    funct3_i;
  logic [DW-1:0] op_num1_i, op_num2_i, result_o;
  logic          done_o, busy_o, hold_n_o;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [DW-1:0] exp_q[$];

  ex_muldiv dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .hold_n_i(hold_n_i), .flush_i(flush_i),
    .funct3_i(funct3_i), .word_i(word_i), .op_num1_i(op_num1_i), .op_num2_i(op_num2_i),
    .result_o(result_o), .done_o(done_o), .busy_o(busy_o), .hold_n_o(hold_n_o)
  );

  // clock / watchdog
  always #5 clk = ~clk;
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct packed {
    logic [2:0]    f3;
    logic          w;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [DW-1:0] res;
  } vec_t;
  vec_t vecs[18];

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] ref_model(input logic [2:0] f3, input logic w,
                                              input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [127:0] p;
    logic [31:0]  a32, b32, r32;
    logic [DW-1:0] r;
    a32 = a[31:0];
    b32 = b[31:0];
    r32 = '0;
    r   = '0;
    p   = '0;
    if (w) begin
      case (f3)
        3'b000: r32 = a32 * b32;
        3'b100: if (b32 == 0) r32 = '1;
                else if (a32 == 32'h8000_0000 && b32 == '1) r32 = a32;
                else r32 = $signed(a32) / $signed(b32);
        3'b101: r32 = (b32 == 0) ? '1 : a32 / b32;
        3'b110: if (b32 == 0) r32 = a32;
                else if (a32 == 32'h8000_0000 && b32 == '1) r32 = '0;
                else r32 = $signed(a32) % $signed(b32);
        3'b111: r32 = (b32 == 0) ? a32 : a32 % b32;
        default: r32 = '0;
      endcase
      r = {{32{r32[31]}}, r32};
    end else begin
      case (f3)
        3'b000: r = a * b;
        3'b001: begin p = {{64{a[63]}}, a} * {{64{b[63]}}, b}; r = p[127:64]; end
        3'b010: begin p = {{64{a[63]}}, a} * {64'b0, b};       r = p[127:64]; end
        3'b011: begin p = {64'b0, a} * {64'b0, b};             r = p[127:64]; end
        3'b100: if (b == 0) r = '1;
                else if (a == 64'h8000_0000_0000_0000 && b == '1) r = a;
                else r = $signed(a) / $signed(b);
        3'b101: r = (b == 0) ? '1 : a / b;
        3'b110: if (b == 0) r = a;
                else if (a == 64'h8000_0000_0000_0000 && b == '1) r = '0;
                else r = $signed(a) % $signed(b);
        default: r = (b == 0) ? a : a % b;
      endcase
    end
    return r;
  endfunction

  function automatic int exp_lat(input logic [2:0] f3, input logic w,
                                 input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic sgn, zero, ovf;
    sgn  = (f3 == 3'b100) || (f3 == 3'b110);
    zero = w ? (b[31:0] == 0) : (b == 0);
    ovf  = sgn && (w ? (a[31:0] == 32'h8000_0000 && b[31:0] == '1)
                     : (a == 64'h8000_0000_0000_0000 && b == '1));
    if (f3[2] && (zero || ovf)) return 1;
`ifdef MULDIV_FAST_MUL_EN
    if (!f3[2]) return 1;
`endif
    return w ? 34 : 66;
  endfunction

  // driver: one complete operation, cycle 0 = the cycle start_i is presented
  task automatic run_op(input string name, input logic [2:0] f3, input logic w,
                        input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [DW-1:0] e);
    int cyc, lat;
    logic hold_ok;
    lat = exp_lat(f3, w, a, b);
    @(negedge clk);
    funct3_i = f3; word_i = w; op_num1_i = a; op_num2_i = b; start_i = 1'b1;
    exp_q.push_back(e);
    #1 check({name, ".hold0"}, hold_n_o, 0);
    @(negedge clk);
    start_i = 1'b0;
    cyc = 1;
    hold_ok = 1'b1;
    while (!done_o && cyc < 200) begin
      if (hold_n_o !== 1'b0) hold_ok = 1'b0;
      @(negedge clk);
      cyc++;
    end
    check({name, ".hold_low"}, hold_ok, 1);
    if (!done_o) begin
      check({name, ".timeout"}, 0, 1);
      void'(exp_q.pop_front());
    end else begin
      check({name, ".lat"}, cyc, lat);
      check({name, ".res"}, result_o, exp_q.pop_front());
      check({name, ".hold_done"}, hold_n_o, 1);
      @(negedge clk);
      check({name, ".pulse"}, done_o, 0);
    end
  endtask

  initial begin
    int cyc;
    logic seen;
    logic [DW-1:0] e, ra, rb;
    logic [2:0] rf;
    logic rw;

    vecs[0]  = '{3'b000, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB};
    vecs[1]  = '{3'b100, 1'b1, 64'h0000_0000_8000_0000, '1, 64'hFFFF_FFFF_8000_0000};
    vecs[2]  = '{3'b111, 1'b0, 64'd100, 64'd0, 64'd100};
    vecs[3]  = '{3'b101, 1'b0, 64'd100, 64'd0, '1};
    vecs[4]  = '{3'b110, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, '1};
    vecs[5]  = '{3'b100, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD};
    vecs[6]  = '{3'b011, 1'b0, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE};
    vecs[7]  = '{3'b100, 1'b1, 64'd20, 64'd3, 64'd6};
    vecs[8]  = '{3'b000, 1'b1, 64'h7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE};
    vecs[9]  = '{3'b110, 1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, '1};
    vecs[10] = '{3'b101, 1'b1, 64'hFFFF_FFFF_FFFF_FFF0, 64'd16, 64'h0FFF_FFFF};
    vecs[11] = '{3'b100, 1'b0, 64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000};
    vecs[12] = '{3'b110, 1'b0, 64'h8000_0000_0000_0000, '1, 64'd0};
    vecs[13] = '{3'b010, 1'b0, '1, 64'd2, '1};
    vecs[14] = '{3'b001, 1'b0, '1, '1, 64'd0};
    vecs[15] = '{3'b111, 1'b1, 64'h0000_0000_8000_0001, 64'hFFFF_FFFF_0000_0000,
                 64'hFFFF_FFFF_8000_0001};
    vecs[16] = '{3'b101, 1'b0, 64'd1000, 64'd7, 64'd142};
    vecs[17] = '{3'b111, 1'b0, 64'd1000, 64'd7, 64'd6};

    // reset
    rst_n = 1'b0; start_i = 1'b0; hold_n_i = 1'b1; flush_i = 1'b0;
    word_i = 1'b0; funct3_i = '0; op_num1_i = '0; op_num2_i = '0;
    repeat (3) @(negedge clk);
    check("rst.result", result_o, 0);
    check("rst.done", done_o, 0);
    check("rst.busy", busy_o, 0);
    check("rst.hold_n", hold_n_o, 1);
    rst_n = 1'b1;

    // table vectors
    for (int i = 0; i < 18; i++)
      run_op($sformatf("vec%0d", i), vecs[i].f3, vecs[i].w, vecs[i].a, vecs[i].b, vecs[i].res);

    // random operations against the behavioural model
    for (int i = 0; i < 16; i++) begin
      rf = 3'($urandom_range(0, 7));
      rw = 1'($urandom_range(0, 1));
      if (rw && rf != 3'b000 && !rf[2]) rf = 3'b000;
      ra = {$urandom, $urandom};
      rb = ($urandom_range(0, 3) == 0) ? 64'($urandom_range(0, 5)) : {$urandom, $urandom};
      run_op($sformatf("rnd%0d", i), rf, rw, ra, rb, ref_model(rf, rw, ra, rb));
    end

    // flush mid-calculation
    @(negedge clk);
    funct3_i = 3'b011; word_i = 1'b0; op_num1_i = '1; op_num2_i = '1; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    cyc = 1;
    while (cyc < 10) begin @(negedge clk); cyc++; end
    check("flush.busy_before", busy_o, 1);
    flush_i = 1'b1;
    #1 check("flush.hold_n", hold_n_o, 1);
    @(negedge clk);
    flush_i = 1'b0;
    check("flush.busy_after", busy_o, 0);
    seen = 1'b0;
    for (int k = 0; k < 80; k++) begin
      if (done_o) seen = 1'b1;
      @(negedge clk);
    end
    check("flush.no_done", seen, 0);

    // flush together with start in IDLE drops the start
    funct3_i = 3'b101; op_num1_i = 64'd100; op_num2_i = 64'd0; start_i = 1'b1; flush_i = 1'b1;
    #1 check("flush_start.hold_n", hold_n_o, 1);
    @(negedge clk);
    start_i = 1'b0; flush_i = 1'b0;
    check("flush_start.busy", busy_o, 0);
    @(negedge clk);
    check("flush_start.done", done_o, 0);
    run_op("restart", 3'b011, 1'b0, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE);

    // hold at completion, ignored start during CALC, start coinciding with DONE->IDLE
    @(negedge clk);
    funct3_i = 3'b100; word_i = 1'b1; op_num1_i = 64'd20; op_num2_i = 64'd3; start_i = 1'b1;
    exp_q.push_back(64'd6);
    @(negedge clk);
    start_i = 1'b0;
    cyc = 1;
    seen = 1'b0;
    while (cyc < 33) begin
      @(negedge clk);
      cyc++;
      if (done_o) seen = 1'b1;
      if (cyc == 5) begin
        funct3_i = 3'b000; word_i = 1'b0; op_num1_i = 64'd1; op_num2_i = 64'd1; start_i = 1'b1;
      end
      if (cyc == 6) start_i = 1'b0;
    end
    check("hold.early_done", seen, 0);
    hold_n_i = 1'b0;
    @(negedge clk);
    e = exp_q.pop_front();
    check("hold.done34", done_o, 1);
    check("hold.res34", result_o, e);
    @(negedge clk);
    check("hold.done35", done_o, 1);
    check("hold.res35", result_o, e);
    @(negedge clk);
    check("hold.done36", done_o, 1);
    check("hold.res36", result_o, e);
    check("hold.hold_n36", hold_n_o, 1);
    hold_n_i = 1'b1;
    funct3_i = 3'b111; word_i = 1'b0; op_num1_i = 64'd100; op_num2_i = 64'd0; start_i = 1'b1;
    exp_q.push_back(64'd100);
    @(negedge clk);
    check("hold.done37", done_o, 0);
    check("hold.busy37", busy_o, 0);
    #1 check("hold.accept37", hold_n_o, 0);
    @(negedge clk);
    start_i = 1'b0;
    check("next.done", done_o, 1);
    check("next.res", result_o, exp_q.pop_front());

    // asynchronous reset mid-operation
    @(negedge clk);
    funct3_i = 3'b000; op_num1_i = 64'd3; op_num2_i = 64'd5; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst.busy", busy_o, 0);
    check("midrst.done", done_o, 0);
    check("midrst.hold_n", hold_n_o, 1);
    check("midrst.result", result_o, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("post_rst", 3'b000, 1'b0, 64'd3, 64'd5, 64'd15);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
